// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline sequencing controller: SRAM FSM states,
// the zero register and branch codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } sram_state_t;

  typedef enum logic [1:0] {
    NO_BRANCH = 2'b00,
    BEZ       = 2'b01,
    BNE       = 2'b10,
    JMP       = 2'b11
  } branch_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register 0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest);
    return (dest != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/sram_wait_fsm.sv
// MEM-stage SRAM handshake: IDLE -> WAIT -> DONE with a timeout counter,
// a level-held request and a sticky timeout error.
module sram_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access,
  input  logic sram_ack,
  output logic sram_req,
  output logic pipe_freeze,
  output logic mem_err
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  sram_state_t   state;
  logic [CW-1:0] wait_cnt;

  // An ack arriving in the final WAIT cycle still counts as a completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      sram_req <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_access) begin
            state    <= WAIT;
            wait_cnt <= '0;
            sram_req <= 1'b1;
          end
        end
        WAIT: begin
          if (sram_ack) begin
            state    <= DONE;
            sram_req <= 1'b0;
          end else if (wait_cnt == LAST_CNT) begin
            state    <= DONE;
            sram_req <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          sram_req <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_freeze = ((state == IDLE) && mem_access) || (state == WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencing for the 5-stage core with a saturating stall counter.
// Define FORWARDING_EN to stall only on load-use hazards.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             id_uses_src2,
  input  logic             br_taken,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ack,
  input  logic             stat_clr,
  output logic             sram_req,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_bubble,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  logic exe_dep;
  logic mem_dep;
  logic load_use;
  logic raw_hazard;

  sram_wait_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_sram_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_access  (mem_r_en | mem_w_en),
    .sram_ack    (sram_ack),
    .sram_req    (sram_req),
    .pipe_freeze (pipe_freeze),
    .mem_err     (mem_err)
  );

  assign exe_dep  = reg_match(src1, exe_dest) | (id_uses_src2 & reg_match(src2, exe_dest));
  assign mem_dep  = reg_match(src1, mem_dest) | (id_uses_src2 & reg_match(src2, mem_dest));
  assign load_use = exe_mem_r_en & exe_wb_en & exe_dep;

`ifdef FORWARDING_EN
  assign raw_hazard = load_use;
`else
  assign raw_hazard = load_use | (exe_wb_en & exe_dep) | (mem_wb_en & mem_dep);
`endif

  // A frozen pipe masks everything; a stale-operand stall masks the branch.
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    id_exe_bubble = 1'b0;
    if_id_flush   = 1'b0;
    if (!pipe_freeze) begin
      if (raw_hazard) begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_exe_bubble = 1'b1;
      end else if (br_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stall_cycles <= '0;
    end else if ((pipe_freeze || raw_hazard) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    src1, src2, exe_dest, mem_dest;
  logic          id_uses_src2, br_taken, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic          mem_r_en, mem_w_en, sram_ack, stat_clr;
  logic          sram_req, pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush;
  logic          pipe_freeze, mem_err;
  logic [CW-1:0] stall_cycles;
  logic [10:0]   observed;

  int checks = 0;
  int fails  = 0;

  bit m_busy, m_release, m_err;
  int m_waited, m_stall;

  pipeline_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .id_uses_src2(id_uses_src2),
    .br_taken(br_taken), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ack(sram_ack), .stat_clr(stat_clr),
    .sram_req(sram_req), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_exe_bubble(id_exe_bubble), .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  assign observed = {sram_req, pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush,
                     pipe_freeze, mem_err, stall_cycles};

  always #5 clk = ~clk;

  // Does the ID instruction read architectural register r?
  function automatic bit reads_reg(input logic [4:0] r);
    return (r != 5'd0) && ((r == src1) || (id_uses_src2 && (r == src2)));
  endfunction

  function automatic bit m_raw();
    bit lu;
    lu = exe_mem_r_en && exe_wb_en && reads_reg(exe_dest);
`ifdef FORWARDING_EN
    return lu;
`else
    return lu || (exe_wb_en && reads_reg(exe_dest)) || (mem_wb_en && reads_reg(mem_dest));
`endif
  endfunction

  function automatic bit m_freeze();
    return m_busy || (!m_release && (mem_r_en || mem_w_en));
  endfunction

  function automatic logic [10:0] m_expect();
    bit f, r, h, fl;
    f  = m_freeze();
    r  = m_raw();
    h  = !f && r;
    fl = !f && !r && br_taken;
    return {m_busy, h, h, h, fl, f, m_err, 4'(m_stall)};
  endfunction

  // Advance the model with this cycle's inputs, then step past the rising edge.
  task automatic advance();
    bit f, r;
    f = m_freeze();
    r = m_raw();
    if (rst) begin
      m_busy = 0; m_release = 0; m_err = 0; m_waited = 0; m_stall = 0;
    end else begin
      if (stat_clr) m_stall = 0;
      else if ((f || r) && m_stall < SAT) m_stall++;
      if (m_busy) begin
        if (sram_ack) begin
          m_busy = 0; m_release = 1;
        end else if (m_waited == TO - 1) begin
          m_busy = 0; m_release = 1; m_err = 1;
        end else begin
          m_waited++;
        end
      end else if (m_release) begin
        m_release = 0;
      end else if (mem_r_en || mem_w_en) begin
        m_busy = 1; m_waited = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
    id_uses_src2 = 0; br_taken = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    mem_r_en = 0; mem_w_en = 0; sram_ack = 0; stat_clr = 0;
  endtask

  task automatic clear_stats();
    clear_inputs();
    stat_clr = 1;
    @(negedge clk);
    advance();
    stat_clr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_r_en = 1; exe_wb_en = 1;
    @(negedge clk); advance();
    @(negedge clk); advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (observed !== 11'b0) begin
      fails++;
      $display("[TB] FAIL reset_state got %b want %b", observed, 11'b0);
    end
    advance();
  endtask

  task automatic test_load_use();
    clear_stats();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; src1 = 5; src2 = 9;
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush} !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL load_use_stall got %b want 1110",
               {pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush});
    end
    advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL load_use_release got %b want 000",
               {pc_freeze, if_id_freeze, id_exe_bubble});
    end
    checks++;
    if (stall_cycles !== 4'd1) begin
      fails++;
      $display("[TB] FAIL load_use_count got %0d want 1", stall_cycles);
    end
    advance();
  endtask

  task automatic test_r0_write();
    clear_inputs();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 0; mem_wb_en = 1; mem_dest = 0;
    src1 = 0; src2 = 0; id_uses_src2 = 1;
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL r0_no_stall got %b want 000", {pc_freeze, if_id_freeze, id_exe_bubble});
    end
    advance();
  endtask

  task automatic test_nonload_raw();
    logic [2:0] want;
`ifdef FORWARDING_EN
    want = 3'b000;
`else
    want = 3'b111;
`endif
    clear_inputs();
    exe_wb_en = 1; exe_dest = 3; src2 = 3; id_uses_src2 = 1; src1 = 7;
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble} !== want) begin
      fails++;
      $display("[TB] FAIL exe_raw_src2 got %b want %b", {pc_freeze, if_id_freeze, id_exe_bubble}, want);
    end
    advance();
    id_uses_src2 = 0;
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL imm_form_no_stall got %b want 000", {pc_freeze, if_id_freeze, id_exe_bubble});
    end
    advance();
    clear_inputs();
    mem_wb_en = 1; mem_dest = 6; src1 = 6;
    @(negedge clk);
    checks++;
    if ({pc_freeze, if_id_freeze, id_exe_bubble} !== want) begin
      fails++;
      $display("[TB] FAIL mem_raw_src1 got %b want %b", {pc_freeze, if_id_freeze, id_exe_bubble}, want);
    end
    advance();
  endtask

  task automatic test_sram_ack();
    bit tbl_mem [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit tbl_ack [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    bit tbl_frz [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    bit tbl_req [10] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0};
    clear_stats();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4; src1 = 4; br_taken = 1;
    for (int i = 0; i < 10; i++) begin
      mem_r_en = tbl_mem[i];
      sram_ack = tbl_ack[i];
      @(negedge clk);
      checks++;
      if ({pipe_freeze, sram_req} !== {tbl_frz[i], tbl_req[i]}) begin
        fails++;
        $display("[TB] FAIL sram_freeze_req cyc%0d got %b want %b", i,
                 {pipe_freeze, sram_req}, {tbl_frz[i], tbl_req[i]});
      end
      checks++;
      if ({pc_freeze, id_exe_bubble, if_id_flush} !== {!tbl_frz[i], !tbl_frz[i], 1'b0}) begin
        fails++;
        $display("[TB] FAIL sram_masking cyc%0d got %b want %b", i,
                 {pc_freeze, id_exe_bubble, if_id_flush}, {!tbl_frz[i], !tbl_frz[i], 1'b0});
      end
      if (i == 9) begin
        checks++;
        if (stall_cycles !== 4'd9 || mem_err !== 1'b0) begin
          fails++;
          $display("[TB] FAIL sram_count got cnt=%0d err=%b want cnt=9 err=0", stall_cycles, mem_err);
        end
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    advance();
  endtask

  task automatic test_timeout();
    bit tbl_mem [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit tbl_ack [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    bit tbl_frz [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    bit tbl_req [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    bit tbl_err [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      mem_w_en = tbl_mem[i];
      sram_ack = tbl_ack[i];
      @(negedge clk);
      checks++;
      if ({pipe_freeze, sram_req, mem_err} !== {tbl_frz[i], tbl_req[i], tbl_err[i]}) begin
        fails++;
        $display("[TB] FAIL timeout_seq cyc%0d got %b want %b", i,
                 {pipe_freeze, sram_req, mem_err}, {tbl_frz[i], tbl_req[i], tbl_err[i]});
      end
      advance();
    end
    clear_inputs();
    rst = 1;
    @(negedge clk);
    advance();
    rst = 0;
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0 || stall_cycles !== 4'd0) begin
      fails++;
      $display("[TB] FAIL timeout_rst_clear got err=%b cnt=%0d want err=0 cnt=0", mem_err, stall_cycles);
    end
    advance();
  endtask

  task automatic test_branch();
    clear_inputs();
    br_taken = 1;
    @(negedge clk);
    checks++;
    if ({if_id_flush, id_exe_bubble, pc_freeze} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL branch_flush got %b want 100", {if_id_flush, id_exe_bubble, pc_freeze});
    end
    advance();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 12; src2 = 12; id_uses_src2 = 1; src1 = 1;
    @(negedge clk);
    checks++;
    if ({if_id_flush, id_exe_bubble, pc_freeze} !== 3'b011) begin
      fails++;
      $display("[TB] FAIL branch_vs_load_use got %b want 011", {if_id_flush, id_exe_bubble, pc_freeze});
    end
    advance();
  endtask

  task automatic test_saturate();
    int want;
    clear_stats();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 2; src1 = 2;
    for (int i = 0; i < 20; i++) begin
      want = (i < SAT) ? i : SAT;
      @(negedge clk);
      checks++;
      if (stall_cycles !== 4'(want)) begin
        fails++;
        $display("[TB] FAIL stall_saturate cyc%0d got %0d want %0d", i, stall_cycles, want);
      end
      advance();
    end
    stat_clr = 1;
    @(negedge clk);
    advance();
    stat_clr = 0;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd0) begin
      fails++;
      $display("[TB] FAIL stat_clr_wins got %0d want 0", stall_cycles);
    end
    advance();
  endtask

  task automatic test_random();
    logic [10:0] want;
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      src1         = 5'($urandom_range(0, 3));
      src2         = 5'($urandom_range(0, 3));
      exe_dest     = 5'($urandom_range(0, 3));
      mem_dest     = 5'($urandom_range(0, 3));
      id_uses_src2 = 1'($urandom_range(0, 1));
      br_taken     = 1'($urandom_range(0, 1));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      mem_r_en     = ($urandom_range(0, 9) < 3);
      mem_w_en     = ($urandom_range(0, 9) < 1);
      sram_ack     = ($urandom_range(0, 9) < 3);
      stat_clr     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      want = m_expect();
      checks++;
      if (observed !== want) begin
        fails++;
        $display("[TB] FAIL random cyc%0d got %b want %b", i, observed, want);
      end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    m_busy = 0; m_release = 0; m_err = 0; m_waited = 0; m_stall = 0;
    test_reset();
    test_load_use();
    test_r0_write();
    test_nonload_raw();
    test_sram_ack();
    test_timeout();
    test_branch();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
